// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: run/halt/single-step controller issuing one-cycle processor clock enables.
// Rev 1.0 -- initial release.
`default_nettype none

module cpu_step_ctrl #(
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        clk_div,
  input  logic        btn_run,
  input  logic        btn_step,
  output logic        cpu_ce,
  output logic [1:0]  mode,
  output logic        halted,
  output logic [15:0] ce_count
);

  typedef enum logic [1:0] {
    S_HALT = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10
  } state_t;

  localparam logic [19:0] c_deb_max = 20'(DEB_CYCLES - 1);

  logic div_s1_q, div_s2_q, div_hist_q;
  logic w_tick;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      div_s1_q   <= 1'b0;
      div_s2_q   <= 1'b0;
      div_hist_q <= 1'b0;
    end else begin
      div_s1_q   <= clk_div;
      div_s2_q   <= div_s1_q;
      div_hist_q <= div_s2_q;
    end
  end

  assign w_tick = div_s2_q & ~div_hist_q;

  // Index 0 is the run button, index 1 the step button.
  logic [1:0] w_btn_raw;
  logic [1:0] w_press;

  assign w_btn_raw = {btn_step, btn_run};

  generate
    for (genvar b = 0; b < 2; b++) begin : g_btn
      logic        s1_q, s2_q, stable_q, press_q;
      logic [19:0] cnt_q;

      always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
          s1_q     <= 1'b0;
          s2_q     <= 1'b0;
          stable_q <= 1'b0;
          press_q  <= 1'b0;
          cnt_q    <= '0;
        end else begin
          s1_q    <= w_btn_raw[b];
          s2_q    <= s1_q;
          press_q <= 1'b0;
          if (s2_q == stable_q) begin
            cnt_q <= '0;
          end else if (cnt_q == c_deb_max) begin
            cnt_q    <= '0;
            stable_q <= s2_q;
            press_q  <= s2_q;
          end else begin
            cnt_q <= cnt_q + 20'd1;
          end
        end
      end

      assign w_press[b] = press_q;
    end
  endgenerate

  logic w_run_press, w_step_press;
  assign w_run_press  = w_press[0];
  assign w_step_press = w_press[1];

  state_t      state_q, state_d;
  logic        ce_d, cpu_ce_q, halted_q;
  logic [15:0] ce_count_q, ce_count_d;

  always_comb begin
    state_d = state_q;
    ce_d    = 1'b0;
    case (state_q)
      S_HALT: begin
        if (w_run_press)       state_d = S_RUN;
        else if (w_step_press) state_d = S_STEP;
      end
      S_RUN: begin
        ce_d = w_tick;
        if (w_run_press) state_d = S_HALT;
      end
      S_STEP: begin
        // A tick coinciding with run entry is still issued since RUN would emit it.
        if (w_run_press) begin
          state_d = S_RUN;
          ce_d    = w_tick;
        end else if (w_tick) begin
          state_d = S_HALT;
          ce_d    = 1'b1;
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  assign ce_count_d = ce_count_q + {15'd0, ce_d};

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q    <= S_HALT;
      cpu_ce_q   <= 1'b0;
      halted_q   <= 1'b1;
      ce_count_q <= '0;
    end else begin
      state_q    <= state_d;
      cpu_ce_q   <= ce_d;
      halted_q   <= (state_d == S_HALT);
      ce_count_q <= ce_count_d;
    end
  end

  assign cpu_ce   = cpu_ce_q;
  assign mode     = state_q;
  assign halted   = halted_q;
  assign ce_count = ce_count_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_step_ctrl.sv
// tb_cpu_step_ctrl: scoreboard bench for cpu_step_ctrl with DEB_CYCLES=4 and a 10-cycle clk_div.
`default_nettype none

module tb_cpu_step_ctrl;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        clk_div;
  logic        btn_run;
  logic        btn_step;
  logic        cpu_ce;
  logic [1:0]  mode;
  logic        halted;
  logic [15:0] ce_count;

  cpu_step_ctrl #(.DEB_CYCLES(4)) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .clk_div  (clk_div),
    .btn_run  (btn_run),
    .btn_step (btn_step),
    .cpu_ce   (cpu_ce),
    .mode     (mode),
    .halted   (halted),
    .ce_count (ce_count)
  );

  initial forever #5 clk_in = ~clk_in;

  typedef struct {
    int          cyc;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          ph = 9;
  logic        div_en = 1'b0;
  logic        exp_run = 1'b0;
  logic        step_pend = 1'b0;
  logic [15:0] exp_cnt = 16'd0;

  task automatic check_eq(input string tag, input int obs, input int exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic step_cycles(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #2;
    end
  endtask

  task automatic press(input logic r, input logic s, input int n);
    btn_run  = r;
    btn_step = s;
    step_cycles(n);
    btn_run  = 1'b0;
    btn_step = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    step_cycles(3);
    exp_cnt = 16'd0;
    reset = 1'b1;
    step_cycles(2);
  endtask

  initial forever begin
    @(posedge clk_in);
    cyc++;
  end

  // clk_div source; each rising edge that should produce a pulse enqueues its expected cycle and count.
  initial begin
    clk_div = 1'b0;
    forever begin
      @(negedge clk_in);
      if (div_en) begin
        ph = (ph == 9) ? 0 : ph + 1;
        if (ph == 0) begin
          clk_div = 1'b1;
          if (exp_run || step_pend) begin
            exp_cnt = exp_cnt + 16'd1;
            sb.push_back('{cyc + 3, exp_cnt});
            step_pend = 1'b0;
          end
        end else if (ph == 5) begin
          clk_div = 1'b0;
        end
      end else begin
        ph      = 9;
        clk_div = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk_in);
    if (cpu_ce === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("ce_unexpected", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("ce_cycle", cyc, mon_e.cyc);
        check_eq("ce_count", int'(ce_count), int'(mon_e.cnt));
      end
    end
  end

  initial begin
    int lat;
    int w;
    reset    = 1'b0;
    btn_run  = 1'b0;
    btn_step = 1'b0;
    step_cycles(5);
    check_eq("rst_ce", int'(cpu_ce), 0);
    check_eq("rst_mode", int'(mode), 0);
    check_eq("rst_halted", int'(halted), 1);
    check_eq("rst_count", int'(ce_count), 0);

    reset  = 1'b1;
    div_en = 1'b1;
    step_cycles(100);
    check_eq("idle_mode", int'(mode), 0);
    check_eq("idle_halted", int'(halted), 1);
    check_eq("idle_count", int'(ce_count), 0);

    div_en = 1'b0;
    step_cycles(10);
    btn_run = 1'b1;
    lat = 0;
    while (mode != 2'b01 && lat < 10) begin
      step_cycles(1);
      lat++;
    end
    check_eq("run_entry_mode", int'(mode), 1);
    check_eq("run_latency_ok", int'(lat <= 7), 1);
    step_cycles(10 - lat);
    btn_run = 1'b0;
    step_cycles(10);

    exp_run = 1'b1;
    div_en  = 1'b1;
    step_cycles(195);
    div_en = 1'b0;
    step_cycles(10);
    check_eq("run_pending", sb.size(), 0);
    check_eq("run_count20", int'(ce_count), 20);
    check_eq("run_mode", int'(mode), 1);
    check_eq("run_halted", int'(halted), 0);

    exp_run = 1'b0;
    press(1'b1, 1'b0, 10);
    step_cycles(5);
    check_eq("halt_mode", int'(mode), 0);
    check_eq("halt_halted", int'(halted), 1);

    apply_reset();
    press(1'b0, 1'b1, 50);
    check_eq("step_wait_mode", int'(mode), 2);
    step_pend = 1'b1;
    div_en    = 1'b1;
    step_cycles(40);
    div_en = 1'b0;
    check_eq("step1_mode", int'(mode), 0);
    check_eq("step1_count", int'(ce_count), 1);
    check_eq("step1_pending", sb.size(), 0);

    press(1'b0, 1'b1, 50);
    step_pend = 1'b1;
    div_en    = 1'b1;
    step_cycles(40);
    div_en = 1'b0;
    check_eq("step2_mode", int'(mode), 0);
    check_eq("step2_count", int'(ce_count), 2);

    press(1'b1, 1'b0, 3);
    step_cycles(20);
    check_eq("glitch_mode", int'(mode), 0);
    press(1'b1, 1'b1, 10);
    step_cycles(5);
    check_eq("both_mode", int'(mode), 1);

    exp_run = 1'b1;
    div_en  = 1'b1;
    w = 0;
    while (cpu_ce !== 1'b1 && w < 30) begin
      step_cycles(1);
      w++;
    end
    check_eq("mid_ce_seen", int'(cpu_ce), 1);
    @(negedge clk_in);
    #1;
    exp_run = 1'b0;
    reset   = 1'b0;
    #1;
    check_eq("mid_rst_ce", int'(cpu_ce), 0);
    check_eq("mid_rst_mode", int'(mode), 0);
    check_eq("mid_rst_halted", int'(halted), 1);
    check_eq("mid_rst_count", int'(ce_count), 0);
    exp_cnt = 16'd0;
    @(negedge clk_in);
    #1;
    reset = 1'b1;
    step_cycles(40);
    div_en = 1'b0;
    check_eq("post_rst_mode", int'(mode), 0);
    check_eq("post_rst_count", int'(ce_count), 0);

    press(1'b1, 1'b0, 10);
    step_cycles(5);
    check_eq("wrap_run_mode", int'(mode), 1);
    @(posedge clk_in);
    #2;
    force dut.ce_count_q = 16'hFFFD;
    #1;
    release dut.ce_count_q;
    exp_cnt = 16'hFFFD;
    exp_run = 1'b1;
    div_en  = 1'b1;
    step_cycles(36);
    div_en  = 1'b0;
    exp_run = 1'b0;
    step_cycles(10);
    check_eq("wrap_count", int'(ce_count), 1);
    check_eq("wrap_pending", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
